// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU command path.
// Contents: command width, the NOP and HALT encodings, field slice positions
// inside a 7-bit command, and the instruction sequencer state encoding.
package cpu_pkg;

  localparam int CMD_W = 7;

  localparam logic [CMD_W-1:0] NOP_CMD  = 7'b0000000;
  localparam logic [CMD_W-1:0] HALT_CMD = 7'h7F;

  // Command layout: [6:5] mux A select, [4:3] mux B select, [2:0] ALU opcode
  localparam int MUX_A_MSB = 6;
  localparam int MUX_A_LSB = 5;
  localparam int MUX_B_MSB = 4;
  localparam int MUX_B_LSB = 3;
  localparam int OPC_MSB   = 2;
  localparam int OPC_LSB   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } seq_state_t;

  function automatic logic is_halt(input logic [CMD_W-1:0] cmd);
    return cmd == HALT_CMD;
  endfunction

endpackage

// File: rtl/instr_store.sv
// Instruction store: DEPTH x CMD_W register array.
// Ports:
//   clk              write clock
//   we/waddr/wdata   single write port, takes effect on the clock edge
//   raddr/rdata      single asynchronous read port
// Contents are deliberately not reset so a program survives rst.
module instr_store
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [CMD_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [CMD_W-1:0]  rdata
);

  logic [CMD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer feeding the CPU control FSM.
// A host loads a program into the instruction store while idle, then pulses
// start. The sequencer aligns to the free-running control FSM on cpu_rdy and
// presents one command per FETCH/LOAD/EXECUTE round, NOP otherwise.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   prog_we/addr/data        host write port (accepted only while idle)
//   prog_len                 program length, sampled on start
//   start, abort             run control (abort wins over everything)
//   cpu_rdy                  EXECUTE pulse from the control FSM
//   cmd_out                  registered command to the control FSM
//   pc                       index of current/next instruction
//   busy, done, prog_err     status; done/prog_err are one-cycle pulses
//   retired_cnt              saturating count of completed instructions
//   state_dbg                current sequencer state
// Build option: define INSTR_HALT_OPCODE_EN to treat a stored 7'h7F as HALT.
//
// Handshake: cpu_rdy is a single-cycle pulse; the cycle after it (fetch_slot)
// is the control FSM's FETCH, and cmd_out changes only on the edge ending that
// cycle, so it is stable through LOAD and EXECUTE.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [CMD_W-1:0]  prog_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  input  logic              abort,
  input  logic              cpu_rdy,
  output logic [CMD_W-1:0]  cmd_out,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              prog_err,
  output logic [CNT_W-1:0]  retired_cnt,
  output seq_state_t        state_dbg
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic              issued_q, issued_d;
  logic              fetch_slot_q, fetch_slot_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [CMD_W-1:0]  rd_data;
  logic              store_we;

  assign store_we = prog_we && (state_q == IDLE);

  instr_store #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_store (
    .clk   (clk),
    .we    (store_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (rd_data)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      len_q        <= '0;
      cmd_q        <= NOP_CMD;
      issued_q     <= 1'b0;
      fetch_slot_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      len_q        <= len_d;
      cmd_q        <= cmd_d;
      issued_q     <= issued_d;
      fetch_slot_q <= fetch_slot_d;
      done_q       <= done_d;
      err_q        <= err_d;
      retired_q    <= retired_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    len_d        = len_q;
    cmd_d        = cmd_q;
    issued_d     = issued_q;
    retired_d    = retired_q;
    fetch_slot_d = cpu_rdy;
    done_d       = 1'b0;
    err_d        = prog_we && (state_q != IDLE);

    if (abort) begin
      state_d  = IDLE;
      pc_d     = '0;
      cmd_d    = NOP_CMD;
      issued_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (prog_len == '0) begin
              done_d = 1'b1;
            end else if (prog_len > DEPTH_L) begin
              err_d = 1'b1;
            end else begin
              pc_d    = '0;
              len_d   = prog_len;
              state_d = ARM;
            end
          end
        end
        ARM: begin
          if (cpu_rdy) state_d = RUN;
        end
        RUN: begin
          // Only a cpu_rdy that closes an issued instruction is a retirement;
          // the alignment pulse that ended ARM never reaches here with issued set.
          if (cpu_rdy && issued_q) begin
            issued_d = 1'b0;
            if (retired_q != {CNT_W{1'b1}}) retired_d = retired_q + 1'b1;
            if ({1'b0, pc_q} == len_q - 1'b1) begin
              state_d = IDLE;
              pc_d    = '0;
              done_d  = 1'b1;
            end else begin
              pc_d = pc_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (fetch_slot_q) begin
        if (state_q == RUN) begin
`ifdef INSTR_HALT_OPCODE_EN
          if (is_halt(rd_data)) begin
            cmd_d    = NOP_CMD;
            state_d  = IDLE;
            pc_d     = '0;
            done_d   = 1'b1;
            issued_d = 1'b0;
          end else begin
            cmd_d    = rd_data;
            issued_d = 1'b1;
          end
`else
          cmd_d    = rd_data;
          issued_d = 1'b1;
`endif
        end else begin
          cmd_d = NOP_CMD;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    cmd_out     = cmd_q;
    pc          = pc_q;
    busy        = (state_q != IDLE);
    done        = done_q;
    prog_err    = err_q;
    retired_cnt = retired_q;
    state_dbg   = state_q;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Instruction source directly upstream of the CPU control FSM. It stores a short program written by a host and drives the FSM's 7-bit command input, holding each instruction stable through that FSM's FETCH/LOAD/EXECUTE round. It advances to the next instruction on the FSM's cpu_rdy pulse and drives NOP (7'b0000000: mux A=00, mux B=00, opcode 000) whenever no program is running.

Parameters:
DEPTH, 16, instruction store depth in entries (power of two, 2..256)
ADDR_W, $clog2(DEPTH), address and program-counter width
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
prog_we  in  1  host write strobe for the instruction store
prog_addr  in  ADDR_W  host write address
prog_data  in  7  host write data: [6:5] mux A select, [4:3] mux B select, [2:0] ALU opcode
prog_len  in  ADDR_W+1  number of instructions to run, sampled on start
start  in  1  one-cycle pulse that begins a run
abort  in  1  synchronous stop of a run
cpu_rdy  in  1  EXECUTE-state pulse from the control FSM
cmd_out  out  7  instruction presented to the control FSM
pc  out  ADDR_W  index of the current or next instruction
busy  out  1  high in ARM and RUN
done  out  1  one-cycle pulse when a run completes
prog_err  out  1  one-cycle pulse when a write is rejected
retired_cnt  out  CNT_W  instructions completed since reset; saturates at all-ones

Behaviour:
- Reset values: state IDLE, cmd_out=0, pc=0, busy=0, done=0, prog_err=0, retired_cnt=0, fetch_slot=0. Instruction store contents are retained across rst and are not reset.
- fetch_slot is cpu_rdy registered once, so it is high during the FSM's FETCH cycle.
- cmd_out is a register. It loads only on the edge that ends a fetch_slot cycle. It loads store[pc] when state=RUN, and NOP otherwise. The value is therefore stable through LOAD and EXECUTE.
- Instruction store: register array with asynchronous read. A write takes effect on the edge where prog_we=1.
- Writes are accepted only in IDLE. A write while busy is dropped and pulses prog_err on the next cycle.
- IDLE:
  - On start with prog_len=0: done pulses, state stays IDLE.
  - On start with prog_len>DEPTH: prog_err pulses, state stays IDLE.
  - On start otherwise: pc=0, state goes to ARM.
- ARM: waits for cpu_rdy so the sequencer aligns to the free-running FSM. On cpu_rdy the state goes to RUN. The following fetch_slot edge loads store[0].
- RUN, on cpu_rdy while an issued instruction is being executed:
  - retired_cnt increments.
  - If pc=prog_len-1: state goes to IDLE, pc=0, done pulses on the next cycle. The next fetch_slot edge loads NOP.
  - Otherwise pc increments.
- The cpu_rdy that ends ARM does not count as a retirement. Retirements are tracked with an issued flag, set on each RUN fetch_slot edge.
- abort takes priority over start and cpu_rdy in any state:
  - Next edge: state IDLE, pc=0, cmd_out=NOP immediately (a mid-instruction abort is allowed), busy=0, no done pulse.
  - retired_cnt is not changed.
- start while busy is ignored.
- Simultaneous prog_we and start in IDLE: the write commits first, so the run sees the new data.
- rst asserted mid-run: all outputs return to reset values asynchronously.

Optional Feature:
- Macro INSTR_HALT_OPCODE_EN.
- Defined: a stored value of 7'h7F is a HALT. On its fetch_slot edge it is not issued: cmd_out loads NOP, state goes to IDLE, pc=0, done pulses. The HALT is not counted in retired_cnt.
- Undefined: 7'h7F is an ordinary instruction (mux A=11, mux B=11, opcode 111).

Decomposition:
- Package cpu_pkg:
  - CMD_W=7 and NOP_CMD=7'b0000000
  - HALT_CMD=7'h7F
  - field slice constants for the select and opcode fields
  - enum seq_state_t {IDLE, ARM, RUN}
- One sub-module, instr_store: DEPTH x 7 register array, one write port, one asynchronous read port.

Test Plan:
- Reset, FSM free-running, no start -> cmd_out=0 on every cycle, busy=0, retired_cnt=0.
- Write 0:7'h2B, 1:7'h45, 2:7'h12, prog_len=3, start -> cmd_out holds 2B, then 45, then 12, each stable from LOAD through EXECUTE; then NOP; done pulses once; retired_cnt=3.
- prog_we during RUN at address 1 -> prog_err pulses once, store unchanged, run completes with the original data.
- abort asserted during the LOAD of the 2nd instruction -> next cycle cmd_out=0, busy=0, pc=0, no done pulse, retired_cnt=1.
- start with prog_len=0 -> done pulses once, busy stays 0. start with prog_len=DEPTH+1 -> prog_err pulses once.
- INSTR_HALT_OPCODE_EN defined, program {7'h01, 7'h7F, 7'h03}, prog_len=3 -> only 01 is issued; done pulses at the HALT fetch; retired_cnt=1.
